// File: rtl/bcd_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_subtractor_if
// Brief    : Request/result bundle for the digit-serial BCD subtractor.
//            Master drives operands and start; slave returns status/result.
// Revision : 1.0  initial release
// ============================================================================
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  bout;
  logic                  invalid;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, invalid
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, invalid
  );
endinterface
`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_subtractor
// Brief    : Digit-serial packed-BCD subtractor, diff = A - B - Bin, one digit
//            per clock, least-significant digit first, start/busy/done.
// Revision : 1.0  initial release
// ============================================================================
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_subtractor_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_RUN    = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  diff_q, diff_d;
  logic [IW-1:0] idx_q;
  logic          borrow_q, borrow_d;
  logic          abort_q;
  logic          bout_q;
  logic          invalid_q;
  logic          done_q;

  logic          w_accept;
  logic          w_last;
  logic [DIGITS-1:0] w_bad;
  logic [3:0]    w_a_dig, w_b_dig, w_dig;
  logic [4:0]    w_t;

  assign w_accept = (state_q == S_IDLE) && bus.start;
  assign w_last   = (idx_q == LAST_IDX);

  // Per-digit range check on the operands presented at the accept edge
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit_chk
    assign w_bad[k] = (bus.a[4*k +: 4] > 4'd9) || (bus.b[4*k +: 4] > 4'd9);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: leave IDLE on start, return after the last digit or an abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (abort_q || w_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: busy follows the RUN state, results come straight from registers
  always_comb begin
    bus.busy    = (state_q == S_RUN);
    bus.done    = done_q;
    bus.diff    = diff_q;
    bus.bout    = bout_q;
    bus.invalid = invalid_q;
  end

  // One digit of subtraction; a negative 5-bit result wraps by adding ten
  always_comb begin
    w_a_dig  = a_q[{idx_q, 2'b00} +: 4];
    w_b_dig  = b_q[{idx_q, 2'b00} +: 4];
    w_t      = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {4'b0000, borrow_q};
    w_dig    = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];
    borrow_d = w_t[4];
    diff_d   = diff_q;
    diff_d[{idx_q, 2'b00} +: 4] = w_dig;
  end

  // Datapath: operand latch on accept, digit update while running, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      abort_q   <= 1'b0;
      bout_q    <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_accept) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        diff_q    <= '0;
        bout_q    <= 1'b0;
        invalid_q <= 1'b0;
        idx_q     <= '0;
        borrow_q  <= bus.bin;
        abort_q   <= |w_bad;
      end else if (state_q == S_RUN) begin
        if (abort_q) begin
          invalid_q <= 1'b1;
          diff_q    <= '0;
          bout_q    <= 1'b0;
          done_q    <= 1'b1;
          abort_q   <= 1'b0;
        end else begin
          diff_q   <= diff_d;
          borrow_q <= borrow_d;
          idx_q    <= idx_q + 1'b1;
          if (w_last) begin
            bout_q <= borrow_d;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_subtractor
// Brief    : Directed self-checking bench for bcd_serial_subtractor (4 digits).
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_serial_subtractor;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc;
  int   n;

  bcd_serial_subtractor_if #(.DIGITS(4)) bus ();

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for exactly one edge (E0); returns at E0+#1
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.bin   = bi;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(output int c);
    c = 0;
    while (!bus.done && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",    32'(bus.busy),    32'h0);
    check("rst_done",    32'(bus.done),    32'h0);
    check("rst_diff",    32'(bus.diff),    32'h0);
    check("rst_bout",    32'(bus.bout),    32'h0);
    check("rst_invalid", 32'(bus.invalid), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: 5432 - 1234 = 4198
    start_op(16'h5432, 16'h1234, 1'b0);
    check("basic_busy", 32'(bus.busy), 32'h1);
    wait_done(cyc);
    check("basic_lat",     32'(cyc),         32'd4);
    check("basic_diff",    32'(bus.diff),    32'h4198);
    check("basic_bout",    32'(bus.bout),    32'h0);
    check("basic_invalid", 32'(bus.invalid), 32'h0);
    check("basic_busy_end", 32'(bus.busy),   32'h0);
    @(posedge clk); #1;
    check("basic_done_pulse", 32'(bus.done), 32'h0);
    check("basic_diff_hold",  32'(bus.diff), 32'h4198);

    // Wrap-around: 0000 - 0001
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(cyc);
    check("wrap_lat",  32'(cyc),      32'd4);
    check("wrap_diff", 32'(bus.diff), 32'h9999);
    check("wrap_bout", 32'(bus.bout), 32'h1);

    // Borrow ripple: 1000 - 0001
    start_op(16'h1000, 16'h0001, 1'b0);
    wait_done(cyc);
    check("ripple_diff", 32'(bus.diff), 32'h0999);
    check("ripple_bout", 32'(bus.bout), 32'h0);

    // Borrow in: 9999 - 9999 - 1
    start_op(16'h9999, 16'h9999, 1'b1);
    wait_done(cyc);
    check("bin_diff", 32'(bus.diff), 32'h9999);
    check("bin_bout", 32'(bus.bout), 32'h1);

    // Invalid operand digit
    start_op(16'h12A4, 16'h0001, 1'b0);
    wait_done(cyc);
    check("inv_lat",     32'(cyc),         32'd1);
    check("inv_invalid", 32'(bus.invalid), 32'h1);
    check("inv_diff",    32'(bus.diff),    32'h0);
    check("inv_bout",    32'(bus.bout),    32'h0);
    @(posedge clk); #1;
    check("inv_hold", 32'(bus.invalid), 32'h1);
    start_op(16'h0005, 16'h0003, 1'b0);
    check("inv_clear", 32'(bus.invalid), 32'h0);
    wait_done(cyc);
    check("after_inv_diff", 32'(bus.diff), 32'h0002);

    // Start during a run is ignored, inputs changed after E0 have no effect
    start_op(16'h0050, 16'h0020, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 16'h9999;
    bus.b     = 16'h0000;
    bus.bin   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(cyc);
    check("ign_lat",  32'(cyc),      32'd2);
    check("ign_diff", 32'(bus.diff), 32'h0030);
    check("ign_bout", 32'(bus.bout), 32'h0);
    @(posedge clk); #1;
    check("ign_idle", 32'(bus.busy), 32'h0);

    // Start held high: back-to-back period of DIGITS+1
    bus.start = 1'b1;
    bus.a     = 16'h0100;
    bus.b     = 16'h0001;
    bus.bin   = 1'b0;
    wait_done(cyc);
    check("held1_lat",  32'(cyc),      32'd5);
    check("held1_diff", 32'(bus.diff), 32'h0099);
    bus.a = 16'h0200;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 20);
    bus.start = 1'b0;
    check("held_period", 32'(n),         32'd5);
    check("held2_diff",  32'(bus.diff),  32'h0199);
    @(posedge clk); #1;
    check("held_stop", 32'(bus.busy), 32'h0);

    // Asynchronous reset in the middle of a run
    start_op(16'h0077, 16'h0011, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_busy",    32'(bus.busy),    32'h0);
    check("mrst_done",    32'(bus.done),    32'h0);
    check("mrst_diff",    32'(bus.diff),    32'h0);
    check("mrst_bout",    32'(bus.bout),    32'h0);
    check("mrst_invalid", 32'(bus.invalid), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
    check("mrst_no_done", 32'(n),        32'd0);
    check("mrst_idle",    32'(bus.busy), 32'h0);
    start_op(16'h0009, 16'h0004, 1'b0);
    wait_done(cyc);
    check("mrst_new_lat",  32'(cyc),      32'd4);
    check("mrst_new_diff", 32'(bus.diff), 32'h0005);
    check("mrst_new_bout", 32'(bus.bout), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_serial_subtractor.md
Name: bcd_serial_subtractor

Overview:
- Digit-serial N-digit packed-BCD subtractor computing A - B - Bin, one BCD digit per clock, least-significant digit first.
- Start/busy/done handshake.
- Inverse-operation companion to the team's combinational single-digit BCD adder; shares its packed 4-bit-per-digit format.
- Sits in the decimal arithmetic datapath beside the adder, for counters and display logic that need decrement or difference.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0]
b  input  4*DIGITS  subtrahend, packed BCD
bin  input  1  borrow in
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse when diff/bout/invalid are final
diff  output  4*DIGITS  packed BCD difference
bout  output  1  borrow out; 1 means diff is the ten's-complement result
invalid  output  1  an operand digit was >9 at latch time

Behaviour:
- Reset is asynchronous: when rst_n is low, go to IDLE and clear all of the following to 0: busy, done, diff, bout, invalid, digit index, internal borrow. Reset takes effect immediately, including mid-operation.
- FSM has two states.
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE with start=1 at edge E0:
  - Latch a, b and bin into internal registers.
  - Clear diff and bout to 0.
  - Set index=0, borrow=bin.
  - Check all 2*DIGITS latched digits for values >9.
- Valid operands at E0:
  - Enter RUN; busy=1 after E0.
  - At edges E0+1 .. E0+DIGITS, process digit i = index:
    - t = a_i - b_i - borrow, 5-bit signed.
    - If t<0: diff_i = t+10 and borrow=1. Otherwise diff_i = t and borrow=0.
    - index increments.
  - At edge E0+DIGITS (last digit): bout=final borrow, busy=0, done=1, return to IDLE.
  - Latency: done is high in the cycle following edge E0+DIGITS, for exactly one cycle.
- Invalid operands at E0:
  - Enter RUN with abort flagged.
  - At edge E0+1: invalid=1, diff=0, bout=0, done=1, busy=0, return to IDLE.
- Output holding:
  - diff, bout and invalid hold their values after done until the next accepted start.
  - invalid is cleared on the next accepted start.
  - diff digits update progressively during RUN and are valid only when done=1 or thereafter.
- start while busy=1 is ignored. It is not queued.
- start held high continuously: a new operation is accepted in the cycle in which done is high (IDLE is re-entered at the done edge), so back-to-back operations have a period of DIGITS+1 cycles.
- Input changes on a/b/bin after E0 have no effect on the running operation.
- Wrap-around: 0 - 1 yields all-9s with bout=1. The result is never truncated to a non-BCD digit.
- Every diff digit is always in the range 0..9.

Test Plan (DIGITS=4):
- a=0x5432, b=0x1234, bin=0, start pulse -> busy for 4 cycles; done 1 cycle after the 4th processing edge; diff=0x4198, bout=0, invalid=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0x9999, bout=1.
- a=0x1000, b=0x0001, bin=0 -> borrow ripples through three digits: diff=0x0999, bout=0. Also a=0x9999, b=0x9999, bin=1 -> diff=0x9999, bout=1.
- a=0x12A4, b=0x0001 -> done one cycle after start; invalid=1, diff=0x0000, bout=0. A following valid start clears invalid.
- start pulsed again 2 cycles into a run, with a/b changed -> ignored; original result delivered. start held high -> second result done exactly 5 cycles after the first.
- rst_n low at cycle 2 of a run -> busy, done, diff, bout and invalid read 0 immediately. No done pulse occurs after rst_n rises. A new start then completes normally.
